// File: rtl/sprite_compositor_pkg.sv
// Shared constants and sizing helpers for the sprite compositor.
package sprite_compositor_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam int DEF_SPR_W = 47;
   localparam int DEF_SPR_H = 41;

   localparam logic [11:0] DEF_KEY_COLOR = 12'h428;

   // Width needed to index n distinct values, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sprite ROM address width: all animation frames stored back-to-back.
   function automatic int addr_width(input int nfrm, input int w, input int h);
      return cnt_width(nfrm * w * h);
   endfunction

endpackage

// File: rtl/sprite_compositor_channel.sv
// One sprite channel: shadow/active registers, pending animation frame,
// hit test and ROM address generation (first pipeline stage).
module sprite_compositor_channel
   import sprite_compositor_pkg::*;
#(
   parameter int IDX     = 0,
   parameter int X_W     = 10,
   parameter int Y_W     = 9,
   parameter int SPR_W   = DEF_SPR_W,
   parameter int SPR_H   = DEF_SPR_H,
   parameter int NUM_FRM = 4,
   parameter int ADDR_W  = 13,
   parameter int SEL_W   = 2
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic [X_W-1:0]    col_addr,
   input  logic [Y_W-1:0]    row_addr,
   input  logic              frame_start,
   input  logic              tick_wrap,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [X_W-1:0]    cfg_x,
   input  logic [Y_W-1:0]    cfg_y,
   input  logic              cfg_en,
   input  logic              cfg_anim,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              hit
);

   localparam int FRM_W = cnt_width(NUM_FRM);

   logic [X_W-1:0]    shd_x_q, act_x_q;
   logic [Y_W-1:0]    shd_y_q, act_y_q;
   logic              shd_en_q, act_en_q, shd_anim_q;
   logic [FRM_W-1:0]  frm_pend_q, frm_pend_d, act_frm_q;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              sel_match;
   logic [X_W:0]      col_ext, x_ext, x_end;
   logic [Y_W:0]      row_ext, y_ext, y_end;
   logic [X_W-1:0]    dx;
   logic [Y_W-1:0]    dy;

   // IDX is always below NUM_SPR, so out-of-range selects match no channel.
   assign sel_match = cfg_we && (cfg_sel == SEL_W'(IDX));

   // Shadow registers take configuration writes at any time.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shd_x_q    <= '0;
         shd_y_q    <= '0;
         shd_en_q   <= 1'b0;
         shd_anim_q <= 1'b0;
      end else if (sel_match) begin
         shd_x_q    <= cfg_x;
         shd_y_q    <= cfg_y;
         shd_en_q   <= cfg_en;
         shd_anim_q <= cfg_anim;
      end
   end

   assign frm_pend_d = (frm_pend_q == FRM_W'(NUM_FRM - 1)) ? '0 : frm_pend_q + 1'b1;

   // Pending frame steps on each animation tick while animation is running.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frm_pend_q <= '0;
      end else if (tick_wrap && shd_anim_q) begin
         frm_pend_q <= frm_pend_d;
      end
   end

   // Commit at frame start; a same-edge write is seen only on the next commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_x_q   <= '0;
         act_y_q   <= '0;
         act_en_q  <= 1'b0;
         act_frm_q <= '0;
      end else if (frame_start) begin
         act_x_q   <= shd_x_q;
         act_y_q   <= shd_y_q;
         act_en_q  <= shd_en_q;
         act_frm_q <= frm_pend_q;
      end
   end

   // Hit test in one extra bit so sprites past the right/bottom edge do not wrap.
   always_comb begin
      col_ext = {1'b0, col_addr};
      row_ext = {1'b0, row_addr};
      x_ext   = {1'b0, act_x_q};
      y_ext   = {1'b0, act_y_q};
      x_end   = x_ext + (X_W+1)'(SPR_W);
      y_end   = y_ext + (Y_W+1)'(SPR_H);
      dx      = col_addr - act_x_q;
      dy      = row_addr - act_y_q;
      hit_d   = act_en_q && (col_ext >= x_ext) && (col_ext < x_end)
                         && (row_ext >= y_ext) && (row_ext < y_end);
      addr_d  = '0;
      if (hit_d) begin
         addr_d = ADDR_W'(act_frm_q) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(dy) * ADDR_W'(SPR_W)
                + ADDR_W'(dx);
      end
   end

   // Stage 1 register: ROM address and hit flag leave together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hit_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit_d;
         addr_q <= addr_d;
      end
   end

   assign rom_addr = addr_q;
   assign hit      = hit_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: shared animation tick, per-channel address
// generation, hit alignment to ROM latency and priority colour-key mux.
module sprite_compositor
   import sprite_compositor_pkg::*;
#(
   parameter int                NUM_SPR   = 4,
   parameter int                COLOR_W   = 12,
   parameter int                X_W       = 10,
   parameter int                Y_W       = 9,
   parameter int                SPR_W     = DEF_SPR_W,
   parameter int                SPR_H     = DEF_SPR_H,
   parameter int                NUM_FRM   = 4,
   parameter int                FRM_TICKS = 2_000_000,
   parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(DEF_KEY_COLOR),
   parameter int                ROM_LAT   = 1,
   localparam int               ADDR_W    = addr_width(NUM_FRM, SPR_W, SPR_H),
   localparam int               SEL_W     = cnt_width(NUM_SPR)
)(
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [X_W-1:0]              col_addr,
   input  logic [Y_W-1:0]              row_addr,
   input  logic                        frame_start,
   input  logic                        cfg_we,
   input  logic [SEL_W-1:0]            cfg_sel,
   input  logic [X_W-1:0]              cfg_x,
   input  logic [Y_W-1:0]              cfg_y,
   input  logic                        cfg_en,
   input  logic                        cfg_anim,
   output logic [NUM_SPR*ADDR_W-1:0]   rom_addr,
   input  logic [NUM_SPR*COLOR_W-1:0]  rom_data,
   input  logic [COLOR_W-1:0]          bg_pixel,
   output logic [COLOR_W-1:0]          pix_out
);

   localparam int TICK_W = cnt_width(FRM_TICKS);

   logic [TICK_W-1:0]  tick_q, tick_d;
   logic               tick_wrap;
   logic [NUM_SPR-1:0] hit_s1;
   logic [NUM_SPR-1:0] hit_dly_q [ROM_LAT];
   logic [COLOR_W-1:0] pix_q, pix_d;
   logic [COLOR_W-1:0] spr_pix;

   assign tick_wrap = (tick_q == TICK_W'(FRM_TICKS - 1));
   assign tick_d    = tick_wrap ? '0 : tick_q + 1'b1;

   // Free-running animation tick, wraps every FRM_TICKS cycles.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tick_q <= '0;
      else       tick_q <= tick_d;
   end

   for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
      sprite_compositor_channel #(
         .IDX     (i),
         .X_W     (X_W),
         .Y_W     (Y_W),
         .SPR_W   (SPR_W),
         .SPR_H   (SPR_H),
         .NUM_FRM (NUM_FRM),
         .ADDR_W  (ADDR_W),
         .SEL_W   (SEL_W)
      ) u_ch (
         .clk         (clk),
         .rstn        (rstn),
         .col_addr    (col_addr),
         .row_addr    (row_addr),
         .frame_start (frame_start),
         .tick_wrap   (tick_wrap),
         .cfg_we      (cfg_we),
         .cfg_sel     (cfg_sel),
         .cfg_x       (cfg_x),
         .cfg_y       (cfg_y),
         .cfg_en      (cfg_en),
         .cfg_anim    (cfg_anim),
         .rom_addr    (rom_addr[i*ADDR_W +: ADDR_W]),
         .hit         (hit_s1[i])
      );
   end

   // Delay hit flags by the ROM latency so they line up with rom_data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < ROM_LAT; k++) hit_dly_q[k] <= '0;
      end else begin
         hit_dly_q[0] <= hit_s1;
         for (int k = 1; k < ROM_LAT; k++) hit_dly_q[k] <= hit_dly_q[k-1];
      end
   end

   // Later channels overwrite earlier ones, so the highest index ends on top.
   always_comb begin
      pix_d   = bg_pixel;
      spr_pix = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
         spr_pix = rom_data[i*COLOR_W +: COLOR_W];
         if (hit_dly_q[ROM_LAT-1][i] && (spr_pix != KEY_COLOR)) pix_d = spr_pix;
      end
   end

   // Final stage register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pix_q <= '0;
      else       pix_q <= pix_d;
   end

   assign pix_out = pix_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

   localparam int NUM_SPR = 4;
   localparam int ADDR_W  = 13;
   localparam int FSZ     = 47 * 41;

   logic                       clk = 1'b0;
   logic                       rstn;
   logic [9:0]                 col_addr;
   logic [8:0]                 row_addr;
   logic                       frame_start;
   logic                       cfg_we;
   logic [1:0]                 cfg_sel;
   logic [9:0]                 cfg_x;
   logic [8:0]                 cfg_y;
   logic                       cfg_en;
   logic                       cfg_anim;
   logic [NUM_SPR*ADDR_W-1:0]  rom_addr;
   logic [NUM_SPR*12-1:0]      rom_data;
   logic [11:0]                bg_pixel;
   logic [11:0]                pix_out;

   int n_checks = 0;
   int n_fail   = 0;

   sprite_compositor #(.FRM_TICKS(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .col_addr    (col_addr),
      .row_addr    (row_addr),
      .frame_start (frame_start),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_x       (cfg_x),
      .cfg_y       (cfg_y),
      .cfg_en      (cfg_en),
      .cfg_anim    (cfg_anim),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .bg_pixel    (bg_pixel),
      .pix_out     (pix_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      col_addr = '0; row_addr = '0; frame_start = 1'b0;
      cfg_we = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0; cfg_anim = 1'b0;
      rom_data = '0; bg_pixel = 12'hFFF;
      step();
      step();
      rstn = 1'b1;
   endtask

   task automatic cfg_write(input int sel, input int x, input int y, input bit en, input bit anim);
      cfg_sel = 2'(sel); cfg_x = 10'(x); cfg_y = 9'(y); cfg_en = en; cfg_anim = anim;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic commit();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic set_rom(input logic [11:0] r0, input logic [11:0] r1,
                          input logic [11:0] r2, input logic [11:0] r3);
      rom_data = {r3, r2, r1, r0};
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #1;
      n_checks++;
      if (pix_out !== 12'h000) begin
         n_fail++; $display("FAIL reset_pix: got %h want 000", pix_out);
      end
      n_checks++;
      if (rom_addr !== '0) begin
         n_fail++; $display("FAIL reset_addr: got %h want 0", rom_addr);
      end
      do_reset();
   endtask

   task automatic test_address();
      logic [ADDR_W-1:0] exp_a [5];
      int cols [5];
      int rows [5];
      cols = '{100, 101, 146, 147, 99};
      rows = '{50,  51,  90,  90,  60};
      exp_a = '{13'd0, 13'd48, 13'd1926, 13'd0, 13'd0};
      cfg_write(0, 100, 50, 1'b1, 1'b0);
      commit();
      for (int i = 0; i < 5; i++) begin
         col_addr = 10'(cols[i]); row_addr = 9'(rows[i]);
         step();
         n_checks++;
         if (rom_addr[ADDR_W-1:0] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL addr_ch0 col=%0d row=%0d: got %0d want %0d",
                     cols[i], rows[i], rom_addr[ADDR_W-1:0], exp_a[i]);
         end
      end
      n_checks++;
      if (rom_addr[NUM_SPR*ADDR_W-1:ADDR_W] !== '0) begin
         n_fail++; $display("FAIL addr_other_ch: got %h want 0", rom_addr[NUM_SPR*ADDR_W-1:ADDR_W]);
      end
   endtask

   task automatic test_composite();
      bg_pixel = 12'hFFF;
      set_rom(12'h428, 12'h000, 12'h000, 12'h000);
      col_addr = 10'd100; row_addr = 9'd50;
      step(); step(); step();
      n_checks++;
      if (pix_out !== 12'hFFF) begin
         n_fail++; $display("FAIL key_transparent: got %h want FFF", pix_out);
      end
      set_rom(12'h0F0, 12'h000, 12'h000, 12'h000);
      col_addr = 10'd0; row_addr = 9'd0;
      step(); step(); step();
      n_checks++;
      if (pix_out !== 12'hFFF) begin
         n_fail++; $display("FAIL miss_bg: got %h want FFF", pix_out);
      end
      col_addr = 10'd100; row_addr = 9'd50;
      step(); step();
      n_checks++;
      if (pix_out !== 12'hFFF) begin
         n_fail++; $display("FAIL latency_early: got %h want FFF", pix_out);
      end
      step();
      n_checks++;
      if (pix_out !== 12'h0F0) begin
         n_fail++; $display("FAIL latency_hit: got %h want 0F0", pix_out);
      end
   endtask

   task automatic test_overlap();
      cfg_write(2, 100, 50, 1'b1, 1'b0);
      commit();
      set_rom(12'h00F, 12'h0AA, 12'h0F0, 12'h555);
      col_addr = 10'd100; row_addr = 9'd50;
      step(); step(); step();
      n_checks++;
      if (pix_out !== 12'h0F0) begin
         n_fail++; $display("FAIL overlap_top: got %h want 0F0", pix_out);
      end
      set_rom(12'h00F, 12'h0AA, 12'h428, 12'h555);
      step();
      n_checks++;
      if (pix_out !== 12'h00F) begin
         n_fail++; $display("FAIL overlap_keyed_top: got %h want 00F", pix_out);
      end
      set_rom(12'h428, 12'h0AA, 12'h428, 12'h555);
      step();
      n_checks++;
      if (pix_out !== 12'hFFF) begin
         n_fail++; $display("FAIL overlap_all_keyed: got %h want FFF", pix_out);
      end
   endtask

   task automatic test_animation();
      int tick_m, pend_m, act_m, exp_frm;
      bit fs;
      do_reset();
      col_addr = 10'd100; row_addr = 9'd50;
      cfg_write(0, 100, 50, 1'b1, 1'b1);
      // after edge 1: tick=1, pending=0, active frame=0
      tick_m = 1; pend_m = 0; act_m = 0;
      for (int n = 2; n <= 32; n++) begin
         fs = ((n >= 2) && (n <= 22)) || (n == 31);
         frame_start = fs;
         step();
         exp_frm = act_m;
         if (fs) act_m = pend_m;
         if (tick_m == 3) pend_m = (pend_m + 1) % 4;
         tick_m = (tick_m + 1) % 4;
         if (n >= 3) begin
            n_checks++;
            if (rom_addr[ADDR_W-1:0] !== ADDR_W'(exp_frm * FSZ)) begin
               n_fail++;
               $display("FAIL anim_frame edge=%0d: got %0d want %0d",
                        n, rom_addr[ADDR_W-1:0], exp_frm * FSZ);
            end
         end
      end
      frame_start = 1'b0;
   endtask

   task automatic test_same_edge_write();
      do_reset();
      cfg_write(0, 100, 50, 1'b1, 1'b0);
      commit();
      cfg_sel = 2'd0; cfg_x = 10'd200; cfg_y = 9'd50; cfg_en = 1'b1; cfg_anim = 1'b0;
      cfg_we = 1'b1; frame_start = 1'b1;
      step();
      cfg_we = 1'b0; frame_start = 1'b0;
      col_addr = 10'd101; row_addr = 9'd51;
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd48) begin
         n_fail++; $display("FAIL same_edge_old_x: got %0d want 48", rom_addr[ADDR_W-1:0]);
      end
      col_addr = 10'd201;
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd0) begin
         n_fail++; $display("FAIL same_edge_new_x_early: got %0d want 0", rom_addr[ADDR_W-1:0]);
      end
      commit();
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd48) begin
         n_fail++; $display("FAIL same_edge_new_x: got %0d want 48", rom_addr[ADDR_W-1:0]);
      end
      col_addr = 10'd101;
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd0) begin
         n_fail++; $display("FAIL same_edge_old_x_gone: got %0d want 0", rom_addr[ADDR_W-1:0]);
      end
   endtask

   task automatic test_screen_edge();
      logic [ADDR_W-1:0] exp_a [4];
      int cols [4];
      cols  = '{620, 639, 0, 26};
      exp_a = '{13'd47, 13'd66, 13'd0, 13'd0};
      do_reset();
      cfg_write(0, 620, 50, 1'b1, 1'b0);
      commit();
      row_addr = 9'd51;
      for (int i = 0; i < 4; i++) begin
         col_addr = 10'(cols[i]);
         step();
         n_checks++;
         if (rom_addr[ADDR_W-1:0] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL edge_x620 col=%0d: got %0d want %0d", cols[i], rom_addr[ADDR_W-1:0], exp_a[i]);
         end
      end
      cfg_write(0, 1000, 50, 1'b1, 1'b0);
      commit();
      col_addr = 10'd5;
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd0) begin
         n_fail++; $display("FAIL edge_nowrap col=5: got %0d want 0", rom_addr[ADDR_W-1:0]);
      end
      col_addr = 10'd1010;
      step();
      n_checks++;
      if (rom_addr[ADDR_W-1:0] !== 13'd57) begin
         n_fail++; $display("FAIL edge_x1000 col=1010: got %0d want 57", rom_addr[ADDR_W-1:0]);
      end
   endtask

   task automatic test_reset_midline();
      bg_pixel = 12'hFFF;
      set_rom(12'h0F0, 12'h000, 12'h000, 12'h000);
      step(); step();
      n_checks++;
      if (pix_out !== 12'h0F0) begin
         n_fail++; $display("FAIL midline_pre: got %h want 0F0", pix_out);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if (pix_out !== 12'h000) begin
         n_fail++; $display("FAIL midline_pix: got %h want 000", pix_out);
      end
      n_checks++;
      if (rom_addr !== '0) begin
         n_fail++; $display("FAIL midline_addr: got %h want 0", rom_addr);
      end
      do_reset();
   endtask

   initial begin
      rstn = 1'b0;
      col_addr = '0; row_addr = '0; frame_start = 1'b0;
      cfg_we = 1'b0; cfg_sel = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0; cfg_anim = 1'b0;
      rom_data = '0; bg_pixel = 12'hFFF;
      test_reset();
      test_address();
      test_composite();
      test_overlap();
      test_animation();
      test_same_edge_write();
      test_screen_edge();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
